// File: rtl/pipeline_wb_stage.sv
// MEM/WB pipeline register and write-back stage: load alignment/extension, write-back source select.
// Optional WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter on the retire_cnt port.
module pipeline_wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_in,
    input  logic [XLEN-1:0]   pc4_in,
    input  logic [XLEN-1:0]   alu_in,
    input  logic [XLEN-1:0]   dmem_in,
    input  logic [XLEN-1:0]   imm_in,
    input  logic [1:0]        memtoreg_in,
    input  logic              regwrite_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [2:0]        funct3_in,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [XLEN-1:0]   rf_wd,
    output logic              wb_valid
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_cnt
`endif
);

    localparam int OFFW = $clog2(XLEN / 8);
    localparam int SHW  = OFFW + 3;
    // Bit-shift masks that drop offset bits below halfword / word granularity.
    localparam logic [SHW-1:0] H_MASK = ~SHW'(8);
    localparam logic [SHW-1:0] W_MASK = ~SHW'(24);

    logic              valid_r;
    logic [XLEN-1:0]   pc4_r;
    logic [XLEN-1:0]   alu_r;
    logic [XLEN-1:0]   dmem_r;
    logic [XLEN-1:0]   imm_r;
    logic [1:0]        memtoreg_r;
    logic              regwrite_r;
    logic [REG_AW-1:0] rd_r;
    logic [2:0]        funct3_r;
    logic [XLEN-1:0]   load_s;
    logic [XLEN-1:0]   wd_s;

    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] word,
        input logic [OFFW-1:0] off,
        input logic [2:0]      f3
    );
        logic [SHW-1:0]  sh_b;
        logic [XLEN-1:0] by;
        logic [XLEN-1:0] hw;
        logic [XLEN-1:0] wd;
        logic [XLEN-1:0] res;
        sh_b = {off, 3'b000};
        by   = word >> sh_b;
        hw   = word >> (sh_b & H_MASK);
        wd   = word >> (sh_b & W_MASK);
        case (f3)
            3'b000:  res = XLEN'($signed(by[7:0]));
            3'b100:  res = XLEN'(by[7:0]);
            3'b001:  res = XLEN'($signed(hw[15:0]));
            3'b101:  res = XLEN'(hw[15:0]);
            3'b010:  res = XLEN'($signed(wd[31:0]));
            3'b110:  res = XLEN'(wd[31:0]);
            default: res = word;
        endcase
        return res;
    endfunction

    // MEM/WB capture: flush inserts a bubble, stall holds, otherwise latch all fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            pc4_r      <= '0;
            alu_r      <= '0;
            dmem_r     <= '0;
            imm_r      <= '0;
            memtoreg_r <= 2'b00;
            regwrite_r <= 1'b0;
            rd_r       <= '0;
            funct3_r   <= 3'b000;
        end else if (flush_i) begin
            valid_r    <= 1'b0;
        end else if (!stall_i) begin
            valid_r    <= valid_in;
            pc4_r      <= pc4_in;
            alu_r      <= alu_in;
            dmem_r     <= dmem_in;
            imm_r      <= imm_in;
            memtoreg_r <= memtoreg_in;
            regwrite_r <= regwrite_in;
            rd_r       <= rd_in;
            funct3_r   <= funct3_in;
        end else begin
            valid_r    <= valid_r;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_r;

    // Count each instruction once, at the edge it enters the WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= 64'd0;
        end else if (!flush_i && !stall_i && valid_in) begin
            retire_cnt_r <= retire_cnt_r + 64'd1;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign retire_cnt = retire_cnt_r;
`endif

    // Write-back source select; every memtoreg code maps to a defined source.
    always_comb begin
        load_s = load_extract(dmem_r, alu_r[OFFW-1:0], funct3_r);
        wd_s   = alu_r;
        case (memtoreg_r)
            2'b00:   wd_s = alu_r;
            2'b01:   wd_s = load_s;
            2'b10:   wd_s = pc4_r;
            2'b11:   wd_s = imm_r;
            default: wd_s = alu_r;
        endcase
    end

    assign rf_we    = valid_r & regwrite_r & (rd_r != '0);
    assign rf_wa    = rd_r;
    assign rf_wd    = wd_s;
    assign wb_valid = valid_r;

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Randomized and directed bench for pipeline_wb_stage against an arithmetic reference model.
module tb_pipeline_wb_stage;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall_i = 1'b0, flush_i = 1'b0, valid_in = 1'b0;
    logic [XLEN-1:0]   pc4_in = '0, alu_in = '0, dmem_in = '0, imm_in = '0;
    logic [1:0]        memtoreg_in = 2'b00;
    logic              regwrite_in = 1'b0;
    logic [REG_AW-1:0] rd_in = '0;
    logic [2:0]        funct3_in = 3'b000;
    logic              rf_we, wb_valid;
    logic [REG_AW-1:0] rf_wa;
    logic [XLEN-1:0]   rf_wd;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]       retire_cnt;
`endif

    pipeline_wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .valid_in(valid_in), .pc4_in(pc4_in), .alu_in(alu_in), .dmem_in(dmem_in),
        .imm_in(imm_in), .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
        .rd_in(rd_in), .funct3_in(funct3_in), .rf_we(rf_we), .rf_wa(rf_wa),
        .rf_wd(rf_wd), .wb_valid(wb_valid)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction currently held in WB
    logic              m_valid = 1'b0;
    logic [XLEN-1:0]   m_pc4 = '0, m_alu = '0, m_dmem = '0, m_imm = '0;
    logic [1:0]        m_mtr = 2'b00;
    logic              m_rw = 1'b0;
    logic [REG_AW-1:0] m_rd = '0;
    logic [2:0]        m_f3 = 3'b000;
    logic [63:0]       m_cnt = 64'd0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [31:0] a,
                                               input logic [2:0] f3);
        int unsigned off, v;
        off = a % 4;
        case (f3)
            3'd0: begin v = (d >> (8 * off)) & 255;              if (v >= 128)   v = v - 256;   end
            3'd4: begin v = (d >> (8 * off)) & 255;                                             end
            3'd1: begin v = (d >> (16 * (off / 2))) & 65535;     if (v >= 32768) v = v - 65536; end
            3'd5: begin v = (d >> (16 * (off / 2))) & 65535;                                    end
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [XLEN-1:0] model_wd();
        case (m_mtr)
            2'd0:    return m_alu;
            2'd1:    return model_load(m_dmem, m_alu, m_f3);
            2'd2:    return m_pc4;
            default: return m_imm;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".we"}, 64'(rf_we), 64'(m_valid && m_rw && (m_rd != 0)));
        check_val({tag, ".wa"}, 64'(rf_wa), 64'(m_rd));
        check_val({tag, ".wd"}, 64'(rf_wd), 64'(model_wd()));
        check_val({tag, ".valid"}, 64'(wb_valid), 64'(m_valid));
`ifdef WB_RETIRE_CNT_EN
        check_val({tag, ".cnt"}, retire_cnt, m_cnt);
`endif
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc4 = '0; m_alu = '0; m_dmem = '0; m_imm = '0;
        m_mtr = 2'b00; m_rw = 1'b0; m_rd = '0; m_f3 = 3'b000; m_cnt = 64'd0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (flush_i) begin
            m_valid = 1'b0;
        end else if (!stall_i) begin
            m_valid = valid_in; m_pc4 = pc4_in; m_alu = alu_in; m_dmem = dmem_in;
            m_imm = imm_in; m_mtr = memtoreg_in; m_rw = regwrite_in; m_rd = rd_in;
            m_f3 = funct3_in;
            if (valid_in) m_cnt = m_cnt + 64'd1;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] dmem,
                         input logic [1:0] mtr, input logic [2:0] f3, input logic [4:0] rd);
        stall_i = 1'b0; flush_i = 1'b0; valid_in = v; alu_in = alu; dmem_in = dmem;
        pc4_in = 32'h0000_0104; imm_in = 32'hABCD_E000; memtoreg_in = mtr;
        funct3_in = f3; regwrite_in = 1'b1; rd_in = rd;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".we"}, 64'(rf_we), 64'd0);
        check_val({tag, ".wa"}, 64'(rf_wa), 64'd0);
        check_val({tag, ".wd"}, 64'(rf_wd), 64'd0);
        check_val({tag, ".valid"}, 64'(wb_valid), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check_val({tag, ".cnt"}, retire_cnt, 64'd0);
`endif
    endtask

    logic [2:0]  ld_f3  [6] = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ld_off [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd2, 32'd0};
    logic [31:0] ld_exp [6] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFF7,
                                32'h0000_0080, 32'hFFFF_80F7, 32'h0000_7F01};
    logic [1:0]  mx_sel [3] = '{2'b00, 2'b10, 2'b11};
    logic [31:0] mx_exp [3] = '{32'h0000_0010, 32'h0000_0104, 32'hABCD_E000};

    initial begin
        logic [63:0] cnt0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sub-word loads from a fixed memory word
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ld_off[i], 32'h80F7_7F01, 2'b01, ld_f3[i], 5'd3);
            step("load_model");
            check_val($sformatf("load%0d", i), 64'(rf_wd), 64'(ld_exp[i]));
        end

        // Write-back source mux
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_0010, 32'h0, mx_sel[i], 3'd2, 5'd4);
            step("mux_model");
            check_val($sformatf("mux%0d", i), 64'(rf_wd), 64'(mx_exp[i]));
        end

        // x0 never written; invalid instruction never written
        drive(1'b1, 32'h1, 32'h0, 2'b00, 3'd2, 5'd0);
        step("rd0_model");
        check_val("rd0_we", 64'(rf_we), 64'd0);
        drive(1'b0, 32'h1, 32'h0, 2'b00, 3'd2, 5'd5);
        step("inv_model");
        check_val("inv_we", 64'(rf_we), 64'd0);

        // Stall three cycles, then flush
`ifdef WB_RETIRE_CNT_EN
        cnt0 = retire_cnt;
`else
        cnt0 = 64'd0;
`endif
        drive(1'b1, 32'h0000_0055, 32'h0, 2'b00, 3'd2, 5'd7);
        step("stall_cap");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hDEAD_BEEF, 32'h0, 2'b11, 3'd0, 5'd9);
            stall_i = 1'b1;
            step("stall_model");
            check_val("stall_we", 64'(rf_we), 64'd1);
            check_val("stall_wd", 64'(rf_wd), 64'h55);
        end
        flush_i = 1'b1;
        step("flush_model");
        check_val("flush_valid", 64'(wb_valid), 64'd0);
        check_val("flush_we", 64'(rf_we), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check_val("stall_cnt", retire_cnt, cnt0 + 64'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            stall_i     = ($urandom_range(0, 3) == 0);
            flush_i     = ($urandom_range(0, 7) == 0);
            valid_in    = $urandom_range(0, 1);
            pc4_in      = $urandom;
            alu_in      = $urandom;
            dmem_in     = $urandom;
            imm_in      = $urandom;
            memtoreg_in = 2'($urandom_range(0, 3));
            regwrite_in = $urandom_range(0, 1);
            rd_in       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            funct3_in   = 3'($urandom_range(0, 7));
            step("rand");
        end

`ifdef WB_RETIRE_CNT_EN
        // Counter wrap
        force dut.retire_cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_cnt_r;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(1'b1, 32'h8, 32'h0, 2'b00, 3'd2, 5'd1);
        step("wrap_model");
        check_val("wrap_cnt", retire_cnt, 64'd0);
`endif

        // Asynchronous reset mid-stream, then first capture after release
        drive(1'b1, 32'h0000_0123, 32'h0, 2'b00, 3'd2, 5'd6);
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h0000_0010, 32'h0, 2'b10, 3'd2, 5'd8);
        step("post_rst");
        check_val("post_rst_wd", 64'(rf_wd), 64'h104);
        check_val("post_rst_we", 64'(rf_we), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
